keypad_event_encoder: RTL and testbench

- Parametrised successor of the keypad key-sync stage: synchronises an N-key one-hot-ish key vector and debounces it.
- Encodes the highest-index pressed key into a binary code and queues press (and optional auto-repeat) events in a small FIFO.
- Events leave the FIFO through a valid/ready interface to the instruction/data entry logic.
- Replaces the fixed 20-key, undebounced encoder that had a 2-cycle strobe.

---
 rtl/keypad_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 51 +++++
 rtl/keypad_event_encoder.sv | 185 ++++++++++++++++++
 tb/tb_keypad_event_encoder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types for the keypad event encoder: code width helper, FSM states
// and the queued event layout.
package keypad_pkg;

    localparam int unsigned MAX_CODE_W = 6;

    function automatic int unsigned code_w(input int unsigned num_keys);
        return (num_keys < 2) ? 1 : $clog2(num_keys);
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        REPEAT
    } key_state_t;

    typedef struct packed {
        logic                  rpt;
        logic [MAX_CODE_W-1:0] code;
    } key_event_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with extra-bit pointers and a valid/ready read side.
// The head word reads as zero while empty so stale entries never leak out.
module sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_valid_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             rd_valid_o,
    output logic [WIDTH-1:0] rd_data_o,
    input  logic             rd_ready_i,
    output logic             full_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             empty;
    logic             push;
    logic             pop;

    // A pop in the same cycle frees a slot, so a push into a full queue still lands.
    always_comb begin
        empty      = (wr_ptr_q == rd_ptr_q);
        full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop        = !empty && rd_ready_i;
        push       = wr_valid_i && (!full_o || pop);
        rd_valid_o = !empty;
        rd_data_o  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/keypad_event_encoder.sv
// Synchronises and debounces the key vector, encodes the highest pressed key
// and queues press / auto-repeat events for the entry logic.
module keypad_event_encoder
    import keypad_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = 20,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned REPEAT_DELAY    = 50000,
    parameter int unsigned REPEAT_PERIOD   = 10000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_KEYS-1:0]           keyin,
    input  logic                          repeat_en,
    input  logic                          ovf_clr,
    output logic [code_w(NUM_KEYS)-1:0]   out_code,
    output logic                          out_repeat,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          key_down,
    output logic                          key_strobe,
    output logic                          multi_key,
    output logic                          overflow
);

    localparam int unsigned CODE_W  = code_w(NUM_KEYS);
    localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

    localparam logic [DB_W-1:0]  DB_MAX      = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    function automatic logic [CODE_W-1:0] encode(input logic [NUM_KEYS-1:0] v);
        encode = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (v[i]) encode = i[CODE_W-1:0];
        end
    endfunction

    logic [NUM_KEYS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_KEYS-1:0] s;
    logic [NUM_KEYS-1:0] s_prev_q;
    logic [NUM_KEYS-1:0] d_q;
    logic [NUM_KEYS-1:0] d_d;
    logic [DB_W-1:0]     db_cnt_q;
    logic [DB_W-1:0]     db_cnt_d;
    logic                s_changed;
    logic                db_load;

    key_state_t          state_q;
    logic [REP_W-1:0]    rep_cnt_q;
    logic                strobe_q;
    logic                ev_rpt_q;
    logic [CODE_W-1:0]   ev_code_q;
    logic [CODE_W-1:0]   code_d;
    logic [CODE_W-1:0]   code_q;
    logic                overflow_q;
    logic                fifo_full;
    logic                drop;
    logic [CODE_W:0]     head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= keyin;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        s_changed = (s != s_prev_q);
        db_load   = !s_changed && (db_cnt_q == DB_LAST);
        d_d       = db_load ? s : d_q;
        if (s_changed)
            db_cnt_d = '0;
        else if (db_cnt_q == DB_MAX)
            db_cnt_d = db_cnt_q;
        else
            db_cnt_d = db_cnt_q + DB_W'(1);
        code_d    = encode(d_d);
        code_q    = encode(d_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_prev_q <= '0;
            db_cnt_q <= '0;
            d_q      <= '0;
        end else begin
            s_prev_q <= s;
            db_cnt_q <= db_cnt_d;
            d_q      <= d_d;
        end
    end

    // The FSM looks at d_d so the strobe rises on the same edge d is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rep_cnt_q <= '0;
            strobe_q  <= 1'b0;
            ev_rpt_q  <= 1'b0;
            ev_code_q <= '0;
        end else begin
            strobe_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    rep_cnt_q <= '0;
                    if (|d_d) begin
                        strobe_q  <= 1'b1;
                        ev_rpt_q  <= 1'b0;
                        ev_code_q <= code_d;
                        state_q   <= HELD;
                    end
                end
                HELD, REPEAT: begin
                    if (!(|d_d)) begin
                        rep_cnt_q <= '0;
                        state_q   <= IDLE;
                    end else if (code_d != code_q) begin
                        strobe_q  <= 1'b1;
                        ev_rpt_q  <= 1'b0;
                        ev_code_q <= code_d;
                        rep_cnt_q <= '0;
                        state_q   <= HELD;
                    end else if (!repeat_en) begin
                        rep_cnt_q <= '0;
                        state_q   <= HELD;
                    end else if ((state_q == HELD   && rep_cnt_q == DELAY_LAST) ||
                                 (state_q == REPEAT && rep_cnt_q == PERIOD_LAST)) begin
                        strobe_q  <= 1'b1;
                        ev_rpt_q  <= 1'b1;
                        ev_code_q <= code_d;
                        rep_cnt_q <= '0;
                        state_q   <= REPEAT;
                    end else begin
                        rep_cnt_q <= rep_cnt_q + REP_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign drop = strobe_q && fifo_full && !out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overflow_q <= 1'b0;
        else if (drop)
            overflow_q <= 1'b1;
        else if (ovf_clr)
            overflow_q <= 1'b0;
    end

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CODE_W + 1)
    ) u_fifo (
        .clk_i      (clk),
        .rst_i      (rst),
        .wr_valid_i (strobe_q),
        .wr_data_i  ({ev_rpt_q, ev_code_q}),
        .rd_valid_o (out_valid),
        .rd_data_o  (head),
        .rd_ready_i (out_ready),
        .full_o     (fifo_full)
    );

    assign out_repeat = head[CODE_W];
    assign out_code   = head[CODE_W-1:0];
    assign key_down   = |d_q;
    assign multi_key  = |(d_q & (d_q - NUM_KEYS'(1)));
    assign key_strobe = strobe_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_keypad_event_encoder.sv
// Directed bench for keypad_event_encoder; queued events are checked by a
// scoreboard as the consumer pops them.
module tb_keypad_event_encoder;
    import keypad_pkg::*;

    localparam int unsigned NK = 20;
    localparam int unsigned CW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] keyin = '0;
    logic          repeat_en = 1'b0;
    logic          ovf_clr = 1'b0;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_code;
    logic          out_repeat;
    logic          out_valid;
    logic          key_down;
    logic          key_strobe;
    logic          multi_key;
    logic          overflow;

    int            checks = 0;
    int            failures = 0;
    int            strobes = 0;
    key_event_t    exp_q [$];

    always #5 clk = ~clk;

    keypad_event_encoder #(
        .NUM_KEYS        (NK),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .FIFO_DEPTH      (4),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .keyin      (keyin),
        .repeat_en  (repeat_en),
        .ovf_clr    (ovf_clr),
        .out_code   (out_code),
        .out_repeat (out_repeat),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .key_down   (key_down),
        .key_strobe (key_strobe),
        .multi_key  (multi_key),
        .overflow   (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input logic r, input int code);
        key_event_t e;
        e.rpt  = r;
        e.code = 6'(code);
        exp_q.push_back(e);
    endtask

    // Scoreboard: a pop happens on the next edge whenever valid & ready here.
    always @(negedge clk) begin
        if (!rst) begin
            if (key_strobe) strobes++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", {26'd0, out_repeat, out_code}, 32'hDEAD);
                end else begin
                    key_event_t e;
                    e = exp_q.pop_front();
                    chk("event", {26'd0, out_repeat, out_code}, {26'd0, e.rpt, e.code[CW-1:0]});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int codes [5] = '{1, 2, 4, 6, 9};

        // Reset values
        tick(2);
        chk("rst_valid", out_valid, 0);
        chk("rst_code", out_code, 0);
        chk("rst_repeat", out_repeat, 0);
        chk("rst_key_down", key_down, 0);
        chk("rst_strobe", key_strobe, 0);
        chk("rst_multi", multi_key, 0);
        chk("rst_overflow", overflow, 0);
        rst = 1'b0;
        tick(1);

        // Clean press of key 13, strobe on edge 7
        out_ready = 1'b1;
        keyin = NK'(1) << 13;
        expect_ev(1'b0, 13);
        tick(6);
        chk("press_strobe_early", key_strobe, 0);
        chk("press_down_early", key_down, 0);
        tick(1);
        chk("press_strobe", key_strobe, 1);
        chk("press_down", key_down, 1);
        chk("press_valid_lag", out_valid, 0);
        tick(1);
        chk("press_valid", out_valid, 1);
        chk("press_code", out_code, 13);
        chk("press_strobe_once", key_strobe, 0);
        keyin = '0;
        tick(8);
        chk("release_down", key_down, 0);
        chk("release_strobes", strobes, 1);

        // Glitch of 3 cycles on key 5
        keyin = NK'(1) << 5;
        tick(3);
        keyin = '0;
        tick(10);
        chk("glitch_down", key_down, 0);
        chk("glitch_strobes", strobes, 1);

        // Multi-key priority, then drop the higher key
        keyin = (NK'(1) << 3) | (NK'(1) << 17);
        expect_ev(1'b0, 17);
        tick(8);
        chk("multi_flag", multi_key, 1);
        chk("multi_down", key_down, 1);
        chk("multi_strobes", strobes, 2);
        keyin = NK'(1) << 3;
        expect_ev(1'b0, 3);
        tick(8);
        chk("single_flag", multi_key, 0);
        chk("drop17_strobes", strobes, 3);
        keyin = '0;
        tick(8);

        // Auto-repeat on key 0: press, then +20, +28, +36
        repeat_en = 1'b1;
        keyin = NK'(1);
        expect_ev(1'b0, 0);
        tick(7);
        chk("rep_press", key_strobe, 1);
        expect_ev(1'b1, 0);
        tick(19);
        chk("rep_first_early", key_strobe, 0);
        tick(1);
        chk("rep_first", key_strobe, 1);
        expect_ev(1'b1, 0);
        tick(7);
        chk("rep_second_early", key_strobe, 0);
        tick(1);
        chk("rep_second", key_strobe, 1);
        expect_ev(1'b1, 0);
        tick(8);
        chk("rep_third", key_strobe, 1);
        repeat_en = 1'b0;
        tick(1);
        s0 = strobes;
        tick(30);
        chk("rep_stopped", strobes, s0);
        keyin = '0;
        tick(8);

        // Overflow: five presses into a four-entry queue with no consumer
        out_ready = 1'b0;
        s0 = strobes;
        for (int k = 0; k < 5; k++) begin
            keyin = NK'(1) << codes[k];
            if (k < 4) expect_ev(1'b0, codes[k]);
            tick(8);
            keyin = '0;
            tick(8);
            if (k == 3) chk("ovf_not_yet", overflow, 0);
        end
        chk("ovf_set", overflow, 1);
        chk("ovf_strobes", strobes - s0, 5);
        chk("ovf_head_code", out_code, 1);
        chk("ovf_head_valid", out_valid, 1);
        out_ready = 1'b1;
        tick(6);
        chk("ovf_drained", exp_q.size(), 0);
        chk("ovf_empty", out_valid, 0);
        chk("ovf_sticky", overflow, 1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("ovf_cleared", overflow, 0);

        // Async reset with two events queued and key held
        out_ready = 1'b0;
        keyin = NK'(1) << 7;
        tick(8);
        keyin = '0;
        tick(8);
        keyin = NK'(1) << 11;
        tick(8);
        chk("prereset_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("reset_valid", out_valid, 0);
        chk("reset_down", key_down, 0);
        exp_q.delete();
        tick(2);
        rst = 1'b0;
        out_ready = 1'b1;
        expect_ev(1'b0, 11);
        tick(6);
        chk("rearm_strobe_early", key_strobe, 0);
        tick(1);
        chk("rearm_strobe", key_strobe, 1);
        tick(3);
        keyin = '0;
        tick(8);
        chk("final_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
